// File: rtl/key_ctrl_pkg.sv
// Shared sizing constants and FSM state encoding for the key loading path.
package key_ctrl_pkg;

  localparam int KEY_W  = 128;
  localparam int WORD_W = 32;
  localparam int NWORDS = KEY_W / WORD_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    LOCKED = 2'd3
  } state_t;

endpackage

// File: rtl/key_assembler.sv
// Shift register that assembles a key from MSW-first words, with a word counter.
// done flags the cycle in which the final word of the key is being accepted.
module key_assembler #(
  parameter int KEY_W  = 128,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [WORD_W-1:0] word_data,
  output logic [KEY_W-1:0]  key_buf,
  output logic              done
);

  localparam int NW    = KEY_W / WORD_W;
  localparam int CNT_W = $clog2(NW + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NW - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NW);

  logic [KEY_W-1:0] key_buf_reg;
  logic [CNT_W-1:0] count_reg;

  // Shift in accepted words; clear has priority so a restart drops any same-cycle word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_buf_reg <= '0;
      count_reg   <= '0;
    end else if (clear) begin
      key_buf_reg <= '0;
      count_reg   <= '0;
    end else if (shift_en) begin
      key_buf_reg <= {key_buf_reg[KEY_W-WORD_W-1:0], word_data};
      // Saturate so the count can never run past a full key.
      if (count_reg != CNT_FULL) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign key_buf = key_buf_reg;
  assign done    = shift_en && (count_reg == CNT_LAST);

endmodule

// File: rtl/key_load_ctrl.sv
// Key load controller: gathers NWORDS words, commits them to key storage with a
// single write strobe, supports clear-to-zero and a lock that only reset releases.
module key_load_ctrl #(
  parameter int KEY_W  = key_ctrl_pkg::KEY_W,
  parameter int WORD_W = key_ctrl_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  input  logic              key_clear,
  input  logic              key_lock,
  output logic              key_write,
  output logic [KEY_W-1:0]  key_data_out,
  output logic              busy,
  output logic              locked,
  output logic              err
);

  import key_ctrl_pkg::*;

  state_t           state_reg;
  logic             word_ready_reg;
  logic             key_write_reg;
  logic             busy_reg;
  logic             locked_reg;
  logic             err_reg;
  logic             asm_clear;
  logic             asm_shift;
  logic             asm_done;
  logic [KEY_W-1:0] key_buf;

  // A load_start in LOAD restarts the key, so the word offered alongside it is dropped.
  assign asm_shift = (state_reg == LOAD) && word_valid && !load_start;

  // Buffer is zeroed when a clear/load begins, on restart, and right after a commit.
  assign asm_clear = ((state_reg == IDLE) && !key_lock && (key_clear || load_start)) ||
                     ((state_reg == LOAD) && load_start) ||
                     (state_reg == COMMIT);

  key_assembler #(
    .KEY_W  (KEY_W),
    .WORD_W (WORD_W)
  ) u_assembler (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .word_data (word_data),
    .key_buf   (key_buf),
    .done      (asm_done)
  );

  // Control FSM; every status output is registered together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      word_ready_reg <= 1'b0;
      key_write_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      locked_reg     <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (key_lock) begin
            state_reg  <= LOCKED;
            locked_reg <= 1'b1;
          end else if (key_clear) begin
            state_reg     <= COMMIT;
            busy_reg      <= 1'b1;
            key_write_reg <= 1'b1;
          end else if (load_start) begin
            state_reg      <= LOAD;
            busy_reg       <= 1'b1;
            word_ready_reg <= 1'b1;
          end
        end
        LOAD: begin
          if (load_start) begin
            err_reg <= 1'b1;
          end else begin
            if (key_clear || key_lock) begin
              err_reg <= 1'b1;
            end
            if (asm_done) begin
              state_reg      <= COMMIT;
              word_ready_reg <= 1'b0;
              key_write_reg  <= 1'b1;
            end
          end
        end
        COMMIT: begin
          state_reg     <= IDLE;
          busy_reg      <= 1'b0;
          key_write_reg <= 1'b0;
        end
        LOCKED: begin
          err_reg <= load_start || key_clear || key_lock;
        end
        default: begin
          state_reg      <= IDLE;
          word_ready_reg <= 1'b0;
          key_write_reg  <= 1'b0;
          busy_reg       <= 1'b0;
          locked_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign word_ready   = word_ready_reg;
  assign key_write    = key_write_reg;
  assign key_data_out = key_write_reg ? key_buf : '0;
  assign busy         = busy_reg;
  assign locked       = locked_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed bench for key_load_ctrl with hand-computed expected values.
module tb_key_load_ctrl;

  localparam int KEY_W  = 128;
  localparam int WORD_W = 32;

  logic              clk;
  logic              rst_n;
  logic              load_start;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;
  logic              key_clear;
  logic              key_lock;
  logic              key_write;
  logic [KEY_W-1:0]  key_data_out;
  logic              busy;
  logic              locked;
  logic              err;

  int vec_count;
  int miscompare_count;

  key_load_ctrl #(
    .KEY_W  (KEY_W),
    .WORD_W (WORD_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_ready   (word_ready),
    .key_clear    (key_clear),
    .key_lock     (key_lock),
    .key_write    (key_write),
    .key_data_out (key_data_out),
    .busy         (busy),
    .locked       (locked),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [KEY_W-1:0] got,
                           input logic [KEY_W-1:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompare_count++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_vec({tag, ".key_write"}, KEY_W'(key_write), '0);
    check_vec({tag, ".key_data"},  key_data_out,      '0);
    check_vec({tag, ".busy"},      KEY_W'(busy),      '0);
    check_vec({tag, ".word_ready"},KEY_W'(word_ready),'0);
    check_vec({tag, ".locked"},    KEY_W'(locked),    '0);
    check_vec({tag, ".err"},       KEY_W'(err),       '0);
  endtask

  logic [WORD_W-1:0] w034 [4];
  logic [WORD_W-1:0] w037 [4];
  logic [WORD_W-1:0] w035 [8];
  logic              v035 [8];

  initial begin
    vec_count        = 0;
    miscompare_count = 0;
    rst_n      = 1'b0;
    load_start = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;
    key_clear  = 1'b0;
    key_lock   = 1'b0;

    w034 = '{32'h0, 32'h0, 32'h0, 32'h0000_3E0C};
    w037 = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    w035 = '{32'hA000_0001, 32'hDEAD_BEEF, 32'hA000_0002, 32'hDEAD_BEEF,
             32'hDEAD_BEEF, 32'hA000_0003, 32'hDEAD_BEEF, 32'hA000_0004};
    v035 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
    check_idle_outputs("post_reset");

    // Back-to-back load of a small key
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check_vec("load034.word_ready", KEY_W'(word_ready), 128'd1);
    check_vec("load034.busy",       KEY_W'(busy),       128'd1);
    for (int i = 0; i < 4; i++) begin
      word_valid = 1'b1;
      word_data  = w034[i];
      tick();
      if (i < 3) begin
        check_vec($sformatf("load034.nowrite%0d", i), KEY_W'(key_write), 128'd0);
      end
    end
    word_valid = 1'b0;
    check_vec("load034.key_write", KEY_W'(key_write), 128'd1);
    check_vec("load034.key_data",  key_data_out,      128'd15884);
    check_vec("load034.word_ready_commit", KEY_W'(word_ready), 128'd0);
    tick();
    check_vec("load034.write_done", KEY_W'(key_write), 128'd0);
    check_vec("load034.data_zero",  key_data_out,      128'd0);
    check_vec("load034.busy_done",  KEY_W'(busy),      128'd0);

    // Load with gaps in word_valid
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      word_valid = v035[i];
      word_data  = w035[i];
      tick();
      if (i < 7) begin
        check_vec($sformatf("gaps.nowrite%0d", i), KEY_W'(key_write), 128'd0);
      end
    end
    word_valid = 1'b0;
    check_vec("gaps.key_write", KEY_W'(key_write), 128'd1);
    check_vec("gaps.key_data",  key_data_out,
              128'hA0000001_A0000002_A0000003_A0000004);
    tick();

    // Clear in IDLE; request held into COMMIT is ignored without err
    key_clear = 1'b1;
    tick();
    check_vec("clear.key_write", KEY_W'(key_write), 128'd1);
    check_vec("clear.key_data",  key_data_out,      128'd0);
    check_vec("clear.busy",      KEY_W'(busy),      128'd1);
    tick();
    key_clear = 1'b0;
    check_vec("clear.write_done", KEY_W'(key_write), 128'd0);
    check_vec("clear.busy_done",  KEY_W'(busy),      128'd0);
    check_vec("clear.no_err",     KEY_W'(err),       128'd0);

    // Restart after two words; key_clear mid-load flags err but load continues
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    word_valid = 1'b1;
    word_data  = 32'hCAFE_0001;
    tick();
    word_data  = 32'hCAFE_0002;
    tick();
    load_start = 1'b1;
    word_data  = 32'hBAD0_BAD0;
    tick();
    load_start = 1'b0;
    check_vec("restart.err",      KEY_W'(err),       128'd1);
    check_vec("restart.no_write", KEY_W'(key_write), 128'd0);
    for (int i = 0; i < 4; i++) begin
      word_data = w037[i];
      key_clear = (i == 1);
      tick();
      key_clear = 1'b0;
      if (i == 0) check_vec("restart.err_clears", KEY_W'(err), 128'd0);
      if (i == 1) check_vec("load.clear_err",     KEY_W'(err), 128'd1);
    end
    word_valid = 1'b0;
    check_vec("restart.key_write", KEY_W'(key_write), 128'd1);
    check_vec("restart.key_data",  key_data_out,
              128'h11111111_22222222_33333333_44444444);
    tick();

    // Lock, then requests are refused with err
    key_lock = 1'b1;
    tick();
    key_lock = 1'b0;
    check_vec("lock.locked", KEY_W'(locked), 128'd1);
    check_vec("lock.busy",   KEY_W'(busy),   128'd0);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check_vec("lock.load_err",      KEY_W'(err),        128'd1);
    check_vec("lock.load_no_write", KEY_W'(key_write),  128'd0);
    check_vec("lock.no_ready",      KEY_W'(word_ready), 128'd0);
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    check_vec("lock.clear_err",      KEY_W'(err),       128'd1);
    check_vec("lock.clear_no_write", KEY_W'(key_write), 128'd0);
    tick();
    check_vec("lock.idle_no_err", KEY_W'(err),    128'd0);
    check_vec("lock.still",       KEY_W'(locked), 128'd1);
    rst_n = 1'b0;
    #1;
    check_vec("lock.reset_unlocks", KEY_W'(locked), 128'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a load aborts with no write
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    word_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      word_data = 32'h5555_0000 + 32'(i);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort_in_reset");
    word_data = 32'h5555_0003;
    tick();
    check_idle_outputs("abort_held");
    rst_n      = 1'b1;
    word_valid = 1'b0;
    tick();
    check_idle_outputs("abort_after");

    // A fresh load after the abort must see a clean counter and buffer
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    word_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      word_data = w037[3 - i];
      tick();
      if (i < 3) begin
        check_vec($sformatf("fresh.nowrite%0d", i), KEY_W'(key_write), 128'd0);
      end
    end
    word_valid = 1'b0;
    check_vec("fresh.key_write", KEY_W'(key_write), 128'd1);
    check_vec("fresh.key_data",  key_data_out,
              128'h44444444_33333333_22222222_11111111);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
    $finish;
  end

  // Bound total run time so the bench always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
